// File: rtl/proc_switcher_pkg.sv
// Shared types and sizing helpers for the processor bus-ownership switcher.
package proc_switcher_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_GAP   = 2'd3
  } sw_state_e;

  // Processor id width; a single processor id still needs one bit.
  function automatic int unsigned id_width(input int unsigned n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

  // Width of a counter that must hold values 0..max_v.
  function automatic int unsigned cnt_width(input int unsigned max_v);
    if (max_v <= 1) return 1;
    return $clog2(max_v + 1);
  endfunction

endpackage

// File: rtl/proc_switcher_if.sv
// Processor-side strobes/bus and switcher outputs grouped as one interface.
interface proc_switcher_if
  import proc_switcher_pkg::*;
#(
  parameter int unsigned N_PROC = 2,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  localparam int unsigned ID_W = id_width(N_PROC);

  logic [N_PROC-1:0]        pSwitchReq;
  logic [N_PROC*ID_W-1:0]   pSwitchTarget;
  logic [N_PROC-1:0]        pBusy;
  logic [N_PROC-1:0]        pMemEnable;
  logic [N_PROC-1:0]        pMemWrite;
  logic [N_PROC-1:0]        pGpuDraw;
  logic [N_PROC-1:0]        pIack;
  logic [N_PROC-1:0]        pIend;
  logic [N_PROC*ADDR_W-1:0] pMemAddr;
  logic [N_PROC*DATA_W-1:0] pMemDataW;

  logic [N_PROC-1:0]        pEnable;
  logic [ID_W-1:0]          activeId;
  logic                     switching;
  logic                     errTimeout;
  logic                     memEnable;
  logic                     memWrite;
  logic                     gpuDraw;
  logic                     iack;
  logic                     iend;
  logic [ADDR_W-1:0]        memAddr;
  logic [DATA_W-1:0]        memDataW;

  // Processor side.
  modport master (
    output pSwitchReq, pSwitchTarget, pBusy, pMemEnable, pMemWrite,
           pGpuDraw, pIack, pIend, pMemAddr, pMemDataW,
    input  pEnable, activeId, switching, errTimeout, memEnable, memWrite,
           gpuDraw, iack, iend, memAddr, memDataW
  );

  // Switcher side.
  modport slave (
    input  pSwitchReq, pSwitchTarget, pBusy, pMemEnable, pMemWrite,
           pGpuDraw, pIack, pIend, pMemAddr, pMemDataW,
    output pEnable, activeId, switching, errTimeout, memEnable, memWrite,
           gpuDraw, iack, iend, memAddr, memDataW
  );

endinterface

// File: rtl/proc_bus_mux.sv
// N-way combinational selection of one processor's strobes and bus, with a
// zero-force input that blanks every output.
module proc_bus_mux #(
  parameter int unsigned N_PROC = 2,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ID_W   = 1
) (
  input  logic [ID_W-1:0]          sel_i,
  input  logic                     zero_i,
  input  logic [N_PROC-1:0]        mem_enable_i,
  input  logic [N_PROC-1:0]        mem_write_i,
  input  logic [N_PROC-1:0]        gpu_draw_i,
  input  logic [N_PROC-1:0]        iack_i,
  input  logic [N_PROC-1:0]        iend_i,
  input  logic [N_PROC*ADDR_W-1:0] mem_addr_i,
  input  logic [N_PROC*DATA_W-1:0] mem_data_w_i,
  output logic                     mem_enable_o,
  output logic                     mem_write_o,
  output logic                     gpu_draw_o,
  output logic                     iack_o,
  output logic                     iend_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic [DATA_W-1:0]        mem_data_w_o
);

  // An out-of-range select falls through to all zeros, like zero_i.
  always_comb begin
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    gpu_draw_o   = 1'b0;
    iack_o       = 1'b0;
    iend_o       = 1'b0;
    mem_addr_o   = '0;
    mem_data_w_o = '0;
    for (int unsigned i = 0; i < N_PROC; i++) begin
      if (!zero_i && (32'(sel_i) == i)) begin
        mem_enable_o = mem_enable_i[i];
        mem_write_o  = mem_write_i[i];
        gpu_draw_o   = gpu_draw_i[i];
        iack_o       = iack_i[i];
        iend_o       = iend_i[i];
        mem_addr_o   = mem_addr_i[i*ADDR_W +: ADDR_W];
        mem_data_w_o = mem_data_w_i[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/proc_switcher.sv
// Hands shared-bus ownership between processors: the owner requests a switch,
// its outstanding work drains (bounded by a timeout), then a dead gap precedes the new owner.
module proc_switcher
  import proc_switcher_pkg::*;
#(
  parameter int unsigned N_PROC        = 2,
  parameter int unsigned ADDR_W        = 16,
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned BOOT_ID       = 0,
  parameter int unsigned MODE          = 0,
  parameter int unsigned GAP_CYCLES    = 1,
  parameter int unsigned DRAIN_TIMEOUT = 255
) (
  input  logic           CLK,
  input  logic           RESET,
  proc_switcher_if.slave bus
);

  localparam int unsigned ID_W    = id_width(N_PROC);
  localparam int unsigned CNT_MAX = (DRAIN_TIMEOUT > GAP_CYCLES) ? DRAIN_TIMEOUT : GAP_CYCLES;
  localparam int unsigned CNT_W   = cnt_width(CNT_MAX);
  localparam logic [ID_W-1:0] BOOT_ID_L = ID_W'(BOOT_ID);

  sw_state_e        state_q, state_d;
  logic [ID_W-1:0]  active_q, active_d;
  logic [ID_W-1:0]  target_q, target_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             own_req;
  logic             own_busy;
  logic [ID_W-1:0]  own_tgt;
  logic [ID_W-1:0]  succ_id;
  logic [ID_W-1:0]  new_tgt;
  logic [N_PROC-1:0] pen_c;
  logic             mux_zero_c;

  logic              mem_enable_c, mem_write_c, gpu_draw_c, iack_c, iend_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_data_w_c;

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    if (32'(id) + 32'd1 >= N_PROC) return '0;
    else                           return id + ID_W'(1);
  endfunction

  // Only the current owner's request, busy flag and target slice matter.
  always_comb begin
    own_req  = 1'b0;
    own_busy = 1'b0;
    own_tgt  = '0;
    for (int unsigned i = 0; i < N_PROC; i++) begin
      if (32'(active_q) == i) begin
        own_req  = bus.pSwitchReq[i];
        own_busy = bus.pBusy[i];
        own_tgt  = bus.pSwitchTarget[i*ID_W +: ID_W];
      end
    end
  end

  // Invalid or self targets fall back to the round-robin successor.
  always_comb begin
    succ_id = next_id(active_q);
    new_tgt = succ_id;
    if (MODE == 0) begin
      if ((32'(own_tgt) < N_PROC) && (own_tgt != active_q)) new_tgt = own_tgt;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_BOOT;
      active_q <= BOOT_ID_L;
      target_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    unique case (state_q)
      ST_BOOT: begin
        state_d  = ST_RUN;
        active_d = BOOT_ID_L;
        cnt_d    = '0;
      end
      ST_RUN: begin
        if (own_req) begin
          state_d  = ST_DRAIN;
          target_d = new_tgt;
          cnt_d    = '0;
        end
      end
      ST_DRAIN: begin
        // A drained owner wins over a simultaneous timeout: no error then.
        if (!own_busy || (32'(cnt_q) + 32'd1 >= DRAIN_TIMEOUT)) begin
          err_d = own_busy;
          cnt_d = '0;
          if (GAP_CYCLES > 0) begin
            state_d = ST_GAP;
          end else begin
            state_d  = ST_RUN;
            active_d = target_q;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (32'(cnt_q) + 32'd1 >= GAP_CYCLES) begin
          state_d  = ST_RUN;
          active_d = target_q;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_comb begin
    pen_c = '0;
    if (state_q == ST_RUN) begin
      for (int unsigned i = 0; i < N_PROC; i++) begin
        if (32'(active_q) == i) pen_c[i] = 1'b1;
      end
    end
  end

  // DRAIN keeps the old owner visible; BOOT and GAP blank the bus.
  assign mux_zero_c = (state_q == ST_BOOT) || (state_q == ST_GAP);

  proc_bus_mux #(
    .N_PROC (N_PROC),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .ID_W   (ID_W)
  ) u_mux (
    .sel_i        (active_q),
    .zero_i       (mux_zero_c),
    .mem_enable_i (bus.pMemEnable),
    .mem_write_i  (bus.pMemWrite),
    .gpu_draw_i   (bus.pGpuDraw),
    .iack_i       (bus.pIack),
    .iend_i       (bus.pIend),
    .mem_addr_i   (bus.pMemAddr),
    .mem_data_w_i (bus.pMemDataW),
    .mem_enable_o (mem_enable_c),
    .mem_write_o  (mem_write_c),
    .gpu_draw_o   (gpu_draw_c),
    .iack_o       (iack_c),
    .iend_o       (iend_c),
    .mem_addr_o   (mem_addr_c),
    .mem_data_w_o (mem_data_w_c)
  );

  assign bus.pEnable    = pen_c;
  assign bus.activeId   = active_q;
  assign bus.switching  = (state_q == ST_DRAIN) || (state_q == ST_GAP);
  assign bus.errTimeout = err_q;
  assign bus.memEnable  = mem_enable_c;
  assign bus.memWrite   = mem_write_c;
  assign bus.gpuDraw    = gpu_draw_c;
  assign bus.iack       = iack_c;
  assign bus.iend       = iend_c;
  assign bus.memAddr    = mem_addr_c;
  assign bus.memDataW   = mem_data_w_c;

endmodule

// File: tb/tb_proc_switcher.sv
// Directed bench for proc_switcher across four parameter sets sharing one clock.
module tb_proc_switcher;

  logic       clk;
  logic [3:0] rst;
  int unsigned n_checks;
  int unsigned n_fail;

  proc_switcher_if #(.N_PROC(2), .ADDR_W(16), .DATA_W(16)) if0 ();
  proc_switcher_if #(.N_PROC(4), .ADDR_W(16), .DATA_W(16)) if1 ();
  proc_switcher_if #(.N_PROC(3), .ADDR_W(16), .DATA_W(16)) if2 ();
  proc_switcher_if #(.N_PROC(2), .ADDR_W(16), .DATA_W(16)) if3 ();

  proc_switcher #(.N_PROC(2), .ADDR_W(16), .DATA_W(16), .BOOT_ID(0), .MODE(0),
                  .GAP_CYCLES(1), .DRAIN_TIMEOUT(255))
    u0 (.CLK(clk), .RESET(rst[0]), .bus(if0));
  proc_switcher #(.N_PROC(4), .ADDR_W(16), .DATA_W(16), .BOOT_ID(0), .MODE(0),
                  .GAP_CYCLES(1), .DRAIN_TIMEOUT(255))
    u1 (.CLK(clk), .RESET(rst[1]), .bus(if1));
  proc_switcher #(.N_PROC(3), .ADDR_W(16), .DATA_W(16), .BOOT_ID(0), .MODE(1),
                  .GAP_CYCLES(1), .DRAIN_TIMEOUT(255))
    u2 (.CLK(clk), .RESET(rst[2]), .bus(if2));
  proc_switcher #(.N_PROC(2), .ADDR_W(16), .DATA_W(16), .BOOT_ID(1), .MODE(0),
                  .GAP_CYCLES(0), .DRAIN_TIMEOUT(8))
    u3 (.CLK(clk), .RESET(rst[3]), .bus(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned req_own [3] = '{0, 1, 2};
    int unsigned exp_own [3] = '{1, 2, 0};
    logic [2:0]  exp_pen [3] = '{3'b010, 3'b100, 3'b001};
    logic [15:0] exp_adr [3] = '{16'h0B0B, 16'h0C0C, 16'h0A0A};

    n_checks = 0;
    n_fail   = 0;
    rst      = 4'hF;

    if0.pSwitchReq = '0; if0.pSwitchTarget = '0; if0.pBusy = '0;
    if0.pMemEnable = 2'b10; if0.pMemWrite = '0; if0.pGpuDraw = '0;
    if0.pIack = '0; if0.pIend = '0; if0.pMemDataW = '0;
    if0.pMemAddr = {16'hB111, 16'hA000};

    if1.pSwitchReq = '0; if1.pSwitchTarget = '0; if1.pBusy = '0;
    if1.pMemEnable = '0; if1.pMemWrite = '0; if1.pGpuDraw = '0;
    if1.pIack = '0; if1.pIend = '0; if1.pMemDataW = '0;
    if1.pMemAddr = {16'h4444, 16'h3333, 16'h2222, 16'h1111};

    if2.pSwitchReq = '0; if2.pSwitchTarget = 6'b00_00_10; if2.pBusy = '0;
    if2.pMemEnable = '0; if2.pMemWrite = '0; if2.pGpuDraw = '0;
    if2.pIack = '0; if2.pIend = '0; if2.pMemDataW = '0;
    if2.pMemAddr = {16'h0C0C, 16'h0B0B, 16'h0A0A};

    if3.pSwitchReq = '0; if3.pSwitchTarget = '0; if3.pBusy = '0;
    if3.pMemEnable = '0; if3.pMemWrite = '0; if3.pGpuDraw = '0;
    if3.pIack = '0; if3.pIend = '0; if3.pMemDataW = '0;
    if3.pMemAddr = {16'h3E3E, 16'h3D3D};

    tick(); tick();
    #1;
    chk("rst_pen0", 32'(if0.pEnable), 32'h0);
    chk("rst_err0", 32'(if0.errTimeout), 32'h0);
    chk("rst_addr0", 32'(if0.memAddr), 32'h0);

    // Release reset: one BOOT cycle, then the boot owner runs.
    tick();
    rst = 4'h0;
    #1;
    chk("boot_pen0", 32'(if0.pEnable), 32'h0);
    chk("boot_addr0", 32'(if0.memAddr), 32'h0);
    chk("boot_sw0", 32'(if0.switching), 32'h0);
    chk("boot_pen3", 32'(if3.pEnable), 32'h0);
    chk("boot_id3", 32'(if3.activeId), 32'h1);
    tick(); #1;
    chk("run_pen0", 32'(if0.pEnable), 32'h1);
    chk("run_id0", 32'(if0.activeId), 32'h0);
    chk("run_addr0", 32'(if0.memAddr), 32'hA000);
    chk("run_men0", 32'(if0.memEnable), 32'h0);
    chk("run_pen3", 32'(if3.pEnable), 32'h2);
    chk("run_addr3", 32'(if3.memAddr), 32'h3E3E);

    // N=4 targeted switch 0 -> 2 with one gap cycle.
    if1.pSwitchTarget = 8'h02;
    if1.pSwitchReq    = 4'b0001;
    #1;
    chk("t_run_addr1", 32'(if1.memAddr), 32'h1111);
    tick();
    if1.pSwitchReq = '0;
    #1;
    chk("t_drain_sw1", 32'(if1.switching), 32'h1);
    chk("t_drain_pen1", 32'(if1.pEnable), 32'h0);
    chk("t_drain_addr1", 32'(if1.memAddr), 32'h1111);
    tick(); #1;
    chk("t_gap_sw1", 32'(if1.switching), 32'h1);
    chk("t_gap_addr1", 32'(if1.memAddr), 32'h0);
    tick(); #1;
    chk("t_new_pen1", 32'(if1.pEnable), 32'h4);
    chk("t_new_id1", 32'(if1.activeId), 32'h2);
    chk("t_new_addr1", 32'(if1.memAddr), 32'h3333);
    chk("t_new_sw1", 32'(if1.switching), 32'h0);

    // Self-target from owner 2 falls back to successor 3.
    if1.pSwitchTarget = 8'h20;
    if1.pSwitchReq    = 4'b0100;
    tick();
    if1.pSwitchReq = '0;
    tick(); tick(); #1;
    chk("self_id1", 32'(if1.activeId), 32'h3);
    chk("self_pen1", 32'(if1.pEnable), 32'h8);
    chk("self_addr1", 32'(if1.memAddr), 32'h4444);

    // Round-robin ownership 0 -> 1 -> 2 -> 0, target field ignored.
    for (int k = 0; k < 3; k++) begin
      if2.pSwitchReq = 3'(1 << req_own[k]);
      tick();
      if2.pSwitchReq = '0;
      tick(); tick(); #1;
      chk("rr_id", 32'(if2.activeId), 32'(exp_own[k]));
      chk("rr_pen", 32'(if2.pEnable), 32'(exp_pen[k]));
      chk("rr_addr", 32'(if2.memAddr), 32'(exp_adr[k]));
    end

    // Owner 0 busy for 10 drain cycles, well under the timeout.
    if0.pSwitchReq = 2'b01;
    if0.pBusy      = 2'b01;
    tick();
    if0.pSwitchReq = '0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("busy_sw0", 32'(if0.switching), 32'h1);
      chk("busy_addr0", 32'(if0.memAddr), 32'hA000);
      chk("busy_err0", 32'(if0.errTimeout), 32'h0);
      tick();
    end
    if0.pBusy = '0;
    #1;
    chk("busy_last_addr0", 32'(if0.memAddr), 32'hA000);
    chk("busy_last_sw0", 32'(if0.switching), 32'h1);
    tick(); #1;
    chk("busy_gap_addr0", 32'(if0.memAddr), 32'h0);
    chk("busy_gap_pen0", 32'(if0.pEnable), 32'h0);
    chk("busy_gap_err0", 32'(if0.errTimeout), 32'h0);
    tick(); #1;
    chk("busy_new_pen0", 32'(if0.pEnable), 32'h2);
    chk("busy_new_addr0", 32'(if0.memAddr), 32'hB111);
    chk("busy_new_men0", 32'(if0.memEnable), 32'h1);
    chk("busy_new_err0", 32'(if0.errTimeout), 32'h0);

    // Non-owner request is ignored.
    if0.pSwitchReq = 2'b01;
    tick(); #1;
    chk("nonown_sw0", 32'(if0.switching), 32'h0);
    tick(); #1;
    chk("nonown_id0", 32'(if0.activeId), 32'h1);
    chk("nonown_pen0", 32'(if0.pEnable), 32'h2);
    if0.pSwitchReq = '0;

    // Stuck busy with timeout 8 and no gap: forced switch 1 -> 0.
    if3.pSwitchReq = 2'b10;
    if3.pBusy      = 2'b10;
    tick();
    if3.pSwitchReq = '0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("to_sw3", 32'(if3.switching), 32'h1);
      chk("to_err3", 32'(if3.errTimeout), 32'h0);
      tick();
    end
    #1;
    chk("to_pulse3", 32'(if3.errTimeout), 32'h1);
    chk("to_id3", 32'(if3.activeId), 32'h0);
    chk("to_pen3", 32'(if3.pEnable), 32'h1);
    chk("to_sw_off3", 32'(if3.switching), 32'h0);
    tick(); #1;
    chk("to_pulse_end3", 32'(if3.errTimeout), 32'h0);
    if3.pBusy = '0;

    // Zero gap: owner 0 self-target -> 1, enabled two cycles after request.
    if3.pSwitchReq = 2'b01;
    tick();
    if3.pSwitchReq = '0;
    #1;
    chk("g0_drain_sw3", 32'(if3.switching), 32'h1);
    tick(); #1;
    chk("g0_pen3", 32'(if3.pEnable), 32'h2);
    chk("g0_id3", 32'(if3.activeId), 32'h1);
    chk("g0_sw3", 32'(if3.switching), 32'h0);

    // Reset in GAP abandons the 3 -> 2 switch.
    if1.pSwitchTarget = 8'h80;
    if1.pSwitchReq    = 4'b1000;
    tick();
    if1.pSwitchReq = '0;
    tick(); #1;
    chk("rg_gap_sw1", 32'(if1.switching), 32'h1);
    rst[1] = 1'b1;
    #1;
    chk("rg_rst_sw1", 32'(if1.switching), 32'h0);
    chk("rg_rst_id1", 32'(if1.activeId), 32'h0);
    chk("rg_rst_pen1", 32'(if1.pEnable), 32'h0);
    chk("rg_rst_addr1", 32'(if1.memAddr), 32'h0);
    tick();
    rst[1] = 1'b0;
    #1;
    chk("rg_boot_pen1", 32'(if1.pEnable), 32'h0);
    tick(); #1;
    chk("rg_run_pen1", 32'(if1.pEnable), 32'h1);
    chk("rg_run_id1", 32'(if1.activeId), 32'h0);
    chk("rg_run_addr1", 32'(if1.memAddr), 32'h1111);
    tick(); #1;
    chk("rg_hold_id1", 32'(if1.activeId), 32'h0);
    chk("rg_hold_sw1", 32'(if1.switching), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/proc_switcher.md
PROC_SWITCHER -- requirements
Module: proc_switcher

Interface
REQ-001 SHALL have parameter N_PROC, default 2, number of processors (2..8).
REQ-002 SHALL have parameter ADDR_W, default 16, memory address width.
REQ-003 SHALL have parameter DATA_W, default 16, memory write-data width.
REQ-004 SHALL have parameter BOOT_ID, default 0, processor enabled after reset.
REQ-005 SHALL have parameter MODE, default 0, 0 = targeted switch, 1 = round-robin.
REQ-006 SHALL have parameter GAP_CYCLES, default 1, dead cycles between owners (0..15).
REQ-007 SHALL have parameter DRAIN_TIMEOUT, default 255, max DRAIN cycles before forced switch.
REQ-008 SHALL have ports, one clock; reset is asynchronous and active-high:
  CLK  in  1  system clock
  RESET  in  1  asynchronous active-high reset
  pSwitchReq  in  N_PROC  per-processor switch request
  pSwitchTarget  in  N_PROC*ID_W  requested next owner (ID_W = clog2(N_PROC))
  pBusy  in  N_PROC  processor has an outstanding memory/GPU operation
  pMemEnable, pMemWrite, pGpuDraw, pIack, pIend  in  N_PROC each  per-processor strobes
  pMemAddr  in  N_PROC*ADDR_W  per-processor address
  pMemDataW  in  N_PROC*DATA_W  per-processor write data
  pEnable  out  N_PROC  one-hot processor enable
  activeId  out  ID_W  current bus owner
  switching  out  1  high in DRAIN and GAP
  errTimeout  out  1  one-cycle pulse on forced switch
  memEnable, memWrite, gpuDraw, iack, iend  out  1 each  muxed strobes
  memAddr  out  ADDR_W; memDataW  out  DATA_W  muxed bus

Function
REQ-009 SHALL implement states BOOT, RUN, DRAIN, GAP.
REQ-010 BOOT SHALL last one cycle after reset release: pEnable = 0, muxed outputs 0, next RUN with activeId = BOOT_ID.
REQ-011 RUN SHALL drive pEnable = onehot(activeId) and pass the activeId processor's strobes/bus to outputs unchanged, combinationally.
REQ-012 Only pSwitchReq[activeId] SHALL be honoured; requests from other processors are ignored in all states.
REQ-013 On pSwitchReq[activeId] high at RUN edge t, target SHALL be latched and state SHALL be DRAIN at t+1.
REQ-014 Target SHALL be pSwitchTarget slice of activeId in MODE 0, (activeId+1) mod N_PROC in MODE 1; target >= N_PROC or == activeId in MODE 0 SHALL be replaced by (activeId+1) mod N_PROC.
REQ-015 DRAIN SHALL drive pEnable = 0, keep outputs muxed from old owner, and count cycles.
REQ-016 DRAIN SHALL exit when pBusy[old] is low, or when count reaches DRAIN_TIMEOUT (then errTimeout pulses one cycle).
REQ-017 DRAIN exit SHALL go to GAP if GAP_CYCLES > 0, else RUN directly.
REQ-018 GAP SHALL hold pEnable = 0, all muxed outputs 0, for exactly GAP_CYCLES cycles, then RUN with activeId = target.
REQ-019 Latency: request at t, pBusy low -> new owner pEnable high at t+2+GAP_CYCLES.
REQ-020 switching SHALL be high exactly in DRAIN and GAP.
REQ-021 pEnable SHALL never have more than one bit set; muxed outputs SHALL never show a non-owner's signals.

Reset
REQ-022 RESET high SHALL asynchronously force state BOOT, activeId = BOOT_ID, counters 0, pEnable 0, errTimeout 0, muxed outputs 0.
REQ-023 RESET during DRAIN or GAP SHALL abandon the switch; latched target discarded.

Structure
REQ-024 State enum and clog2-based ID_W helper SHALL live in the shared project package.
REQ-025 Bus selection SHALL be one sub-module, proc_bus_mux (combinational, N_PROC-way, zero-force input).

Verification
REQ-026 N_PROC=2, reset release -> cycle 1 BOOT, cycle 2 pEnable=01, activeId=0.
REQ-027 N_PROC=4, MODE 0, owner 0 requests target 2, pBusy low, GAP_CYCLES=1 -> pEnable=0100 three cycles after request, memAddr from p2.
REQ-028 MODE 1, N_PROC=3, three consecutive requests from owners -> ownership 0->1->2->0.
REQ-029 pBusy[0] held 10 cycles, DRAIN_TIMEOUT=255 -> p0 memAddr visible 10 cycles, then switch, no errTimeout.
REQ-030 pBusy stuck, DRAIN_TIMEOUT=8 -> errTimeout single pulse, switch completes.
REQ-031 Non-owner request, and RESET asserted mid-GAP -> no switch; BOOT then activeId=BOOT_ID.
